// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: pixel prescaler, h/v counters, sync/blank
// decode, line/frame strobes and a look-ahead fetch coordinate, all registered.
module vga_timing_gen #(
  parameter int unsigned CLK_DIV  = 2,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 29,
  parameter int unsigned HS_POL   = 0,
  parameter int unsigned VS_POL   = 0,
  parameter int unsigned LEAD     = 4,
  parameter int unsigned COORD_W  = 10
) (
  input  logic               CLOCK_50,
  input  logic               reset,
  input  logic               run,
  output logic               pix_en,
  output logic               HS,
  output logic               VS,
  output logic               blank,
  output logic [COORD_W-1:0] row,
  output logic [COORD_W-1:0] col,
  output logic               line_start,
  output logic               frame_start,
  output logic               fetch_en,
  output logic [COORD_W-1:0] fetch_row,
  output logic [COORD_W-1:0] fetch_col
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned EXT_W   = COORD_W + 1;
  localparam logic        HS_ON   = 1'(HS_POL);
  localparam logic        VS_ON   = 1'(VS_POL);

  logic [DIV_W-1:0]   r_div_cnt;
  logic [COORD_W-1:0] r_h_cnt;
  logic [COORD_W-1:0] r_v_cnt;

  logic               w_pe;
  logic               w_h_last;
  logic               w_v_last;
  logic [EXT_W-1:0]   w_h_ext;
  logic [EXT_W-1:0]   w_v_ext;
  logic               w_hs_act;
  logic               w_vs_act;
  logic               w_blank;
  logic [EXT_W-1:0]   w_fh_sum;
  logic               w_fh_wrap;
  logic [COORD_W-1:0] w_fh;
  logic [COORD_W-1:0] w_fv;
  logic               w_fetch_vis;

  assign w_pe     = (r_div_cnt == DIV_W'(CLK_DIV - 1));
  assign w_h_last = (r_h_cnt == COORD_W'(H_TOTAL - 1));
  assign w_v_last = (r_v_cnt == COORD_W'(V_TOTAL - 1));

  // Decode in one extra bit so region bounds equal to 2**COORD_W still compare correctly.
  assign w_h_ext  = {1'b0, r_h_cnt};
  assign w_v_ext  = {1'b0, r_v_cnt};
  assign w_hs_act = (w_h_ext >= EXT_W'(H_ACTIVE + H_FP)) &&
                    (w_h_ext <  EXT_W'(H_ACTIVE + H_FP + H_SYNC));
  assign w_vs_act = (w_v_ext >= EXT_W'(V_ACTIVE + V_FP)) &&
                    (w_v_ext <  EXT_W'(V_ACTIVE + V_FP + V_SYNC));
  assign w_blank  = (w_h_ext >= EXT_W'(H_ACTIVE)) || (w_v_ext >= EXT_W'(V_ACTIVE));

  // Look-ahead coordinate; LEAD < H_TOTAL so a single wrap step is enough.
  assign w_fh_sum  = w_h_ext + EXT_W'(LEAD);
  assign w_fh_wrap = (w_fh_sum >= EXT_W'(H_TOTAL));
  assign w_fh      = w_fh_wrap ? COORD_W'(w_fh_sum - EXT_W'(H_TOTAL)) : COORD_W'(w_fh_sum);
  assign w_fv      = !w_fh_wrap ? r_v_cnt :
                     (w_v_last ? '0 : r_v_cnt + COORD_W'(1));
  assign w_fetch_vis = ({1'b0, w_fh} < EXT_W'(H_ACTIVE)) &&
                       ({1'b0, w_fv} < EXT_W'(V_ACTIVE));

  // Prescaler and raster counters; held at the origin while stopped.
  always_ff @(posedge CLOCK_50) begin
    if (reset || !run) begin
      r_div_cnt <= '0;
      r_h_cnt   <= '0;
      r_v_cnt   <= '0;
    end else begin
      r_div_cnt <= w_pe ? '0 : r_div_cnt + DIV_W'(1);
      if (w_pe) begin
        r_h_cnt <= w_h_last ? '0 : r_h_cnt + COORD_W'(1);
        if (w_h_last) begin
          r_v_cnt <= w_v_last ? '0 : r_v_cnt + COORD_W'(1);
        end
      end
    end
  end

  // Registered outputs: one cycle behind the counter state they decode.
  always_ff @(posedge CLOCK_50) begin
    if (reset || !run) begin
      pix_en      <= 1'b0;
      HS          <= ~HS_ON;
      VS          <= ~VS_ON;
      blank       <= 1'b1;
      row         <= '0;
      col         <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      fetch_en    <= 1'b0;
      fetch_row   <= '0;
      fetch_col   <= '0;
    end else begin
      pix_en      <= w_pe;
      HS          <= w_hs_act ? HS_ON : ~HS_ON;
      VS          <= w_vs_act ? VS_ON : ~VS_ON;
      blank       <= w_blank;
      row         <= r_v_cnt;
      col         <= r_h_cnt;
      line_start  <= w_pe && (r_h_cnt == '0);
      frame_start <= w_pe && (r_h_cnt == '0) && (r_v_cnt == '0);
      fetch_en    <= w_pe && w_fetch_vis;
      fetch_row   <= w_fv;
      fetch_col   <= w_fh;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboarded bench for vga_timing_gen: three configurations (small/div2, small/div1
// with high-true syncs, default mode) share reset/run and are checked every cycle.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset = 1'b1;
  logic run   = 1'b0;

  typedef struct packed {
    logic       pix_en, hs, vs, blank;
    logic [9:0] row, col;
    logic       ls, fs, fe;
    logic [9:0] frow, fcol;
  } vo_t;

  int cd  [3] = '{2, 1, 2};
  int ha  [3] = '{8, 8, 640};
  int hf  [3] = '{1, 1, 16};
  int hsw [3] = '{2, 2, 96};
  int hb  [3] = '{1, 1, 48};
  int va  [3] = '{4, 4, 480};
  int vf  [3] = '{1, 1, 10};
  int vsw [3] = '{1, 1, 2};
  int vb  [3] = '{1, 1, 29};
  int hp  [3] = '{0, 1, 0};
  int vp  [3] = '{0, 1, 0};
  int ld  [3] = '{3, 3, 4};

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", tag, cyc, got, exp);
    end
  endtask

  // DUT outputs
  logic       a_pe, a_hs, a_vs, a_bl, a_ls, a_fs, a_fe;
  logic [5:0] a_row, a_col, a_frow, a_fcol;
  logic       b_pe, b_hs, b_vs, b_bl, b_ls, b_fs, b_fe;
  logic [5:0] b_row, b_col, b_frow, b_fcol;
  logic       c_pe, c_hs, c_vs, c_bl, c_ls, c_fs, c_fe;
  logic [9:0] c_row, c_col, c_frow, c_fcol;

  vga_timing_gen #(.CLK_DIV(2), .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
                   .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
                   .HS_POL(0), .VS_POL(0), .LEAD(3), .COORD_W(6)) u0 (
    .CLOCK_50(clk), .reset(reset), .run(run), .pix_en(a_pe), .HS(a_hs), .VS(a_vs),
    .blank(a_bl), .row(a_row), .col(a_col), .line_start(a_ls), .frame_start(a_fs),
    .fetch_en(a_fe), .fetch_row(a_frow), .fetch_col(a_fcol));

  vga_timing_gen #(.CLK_DIV(1), .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
                   .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
                   .HS_POL(1), .VS_POL(1), .LEAD(3), .COORD_W(6)) u1 (
    .CLOCK_50(clk), .reset(reset), .run(run), .pix_en(b_pe), .HS(b_hs), .VS(b_vs),
    .blank(b_bl), .row(b_row), .col(b_col), .line_start(b_ls), .frame_start(b_fs),
    .fetch_en(b_fe), .fetch_row(b_frow), .fetch_col(b_fcol));

  vga_timing_gen u2 (
    .CLOCK_50(clk), .reset(reset), .run(run), .pix_en(c_pe), .HS(c_hs), .VS(c_vs),
    .blank(c_bl), .row(c_row), .col(c_col), .line_start(c_ls), .frame_start(c_fs),
    .fetch_en(c_fe), .fetch_row(c_frow), .fetch_col(c_fcol));

  vo_t obs [3];
  always_comb begin
    obs[0] = {a_pe, a_hs, a_vs, a_bl, 4'b0, a_row, 4'b0, a_col, a_ls, a_fs, a_fe,
              4'b0, a_frow, 4'b0, a_fcol};
    obs[1] = {b_pe, b_hs, b_vs, b_bl, 4'b0, b_row, 4'b0, b_col, b_ls, b_fs, b_fe,
              4'b0, b_frow, 4'b0, b_fcol};
    obs[2] = {c_pe, c_hs, c_vs, c_bl, c_row, c_col, c_ls, c_fs, c_fe, c_frow, c_fcol};
  end

  function automatic int htot(input int i);
    return ha[i] + hf[i] + hsw[i] + hb[i];
  endfunction

  function automatic int vtot(input int i);
    return va[i] + vf[i] + vsw[i] + vb[i];
  endfunction

  // Reference: raster position kept as a linear pixel index within the frame.
  function automatic vo_t model(input int i, input int div, input int idx, input bit act);
    vo_t o;
    int  h, v, f, fh, fv;
    bit  pe;
    o       = '0;
    o.hs    = (hp[i] == 0);
    o.vs    = (vp[i] == 0);
    o.blank = 1'b1;
    if (act) begin
      pe       = (div == cd[i] - 1);
      h        = idx % htot(i);
      v        = idx / htot(i);
      f        = (idx + ld[i]) % (htot(i) * vtot(i));
      fh       = f % htot(i);
      fv       = f / htot(i);
      o.pix_en = pe;
      o.hs     = (h >= ha[i] + hf[i] && h < ha[i] + hf[i] + hsw[i]) ? (hp[i] != 0) : (hp[i] == 0);
      o.vs     = (v >= va[i] + vf[i] && v < va[i] + vf[i] + vsw[i]) ? (vp[i] != 0) : (vp[i] == 0);
      o.blank  = (h >= ha[i]) || (v >= va[i]);
      o.row    = 10'(v);
      o.col    = 10'(h);
      o.ls     = pe && (h == 0);
      o.fs     = pe && (idx == 0);
      o.fe     = pe && (fh < ha[i]) && (fv < va[i]);
      o.frow   = 10'(fv);
      o.fcol   = 10'(fh);
    end
    return o;
  endfunction

  vo_t sbq [3][$];
  int  m_div [3] = '{0, 0, 0};
  int  m_idx [3] = '{0, 0, 0};
  bit  hv [3], vv [3], fsv [3];
  int  t_hf [3], t_vf [3], t_fs [3], fcnt [3];
  vo_t prev [3];

  // Push the expectation for this edge, then advance the model.
  always @(posedge clk) begin
    cyc++;
    for (int i = 0; i < 3; i++) begin
      sbq[i].push_back(model(i, m_div[i], m_idx[i], !reset && run));
      if (reset || !run) begin
        m_div[i] = 0;
        m_idx[i] = 0;
        hv[i]    = 1'b0;
        vv[i]    = 1'b0;
        fsv[i]   = 1'b0;
        fcnt[i]  = 0;
      end else if (m_div[i] == cd[i] - 1) begin
        m_div[i] = 0;
        m_idx[i] = (m_idx[i] + 1) % (htot(i) * vtot(i));
      end else begin
        m_div[i] = m_div[i] + 1;
      end
    end
  end

  // Pop and compare away from the active edge; also measure sync/frame periods.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      vo_t e, o;
      bit  hact, phact, vact, pvact;
      o = obs[i];
      if (sbq[i].size() > 0) begin
        e = sbq[i].pop_front();
        chk($sformatf("u%0d.pix_en", i), 32'(o.pix_en), 32'(e.pix_en));
        chk($sformatf("u%0d.hs", i),     32'(o.hs),     32'(e.hs));
        chk($sformatf("u%0d.vs", i),     32'(o.vs),     32'(e.vs));
        chk($sformatf("u%0d.blank", i),  32'(o.blank),  32'(e.blank));
        chk($sformatf("u%0d.row", i),    32'(o.row),    32'(e.row));
        chk($sformatf("u%0d.col", i),    32'(o.col),    32'(e.col));
        chk($sformatf("u%0d.line_start", i),  32'(o.ls), 32'(e.ls));
        chk($sformatf("u%0d.frame_start", i), 32'(o.fs), 32'(e.fs));
        chk($sformatf("u%0d.fetch_en", i),    32'(o.fe), 32'(e.fe));
        chk($sformatf("u%0d.fetch_row", i),   32'(o.frow), 32'(e.frow));
        chk($sformatf("u%0d.fetch_col", i),   32'(o.fcol), 32'(e.fcol));
      end
      hact  = (o.hs == (hp[i] != 0));
      phact = (prev[i].hs == (hp[i] != 0));
      vact  = (o.vs == (vp[i] != 0));
      pvact = (prev[i].vs == (vp[i] != 0));
      if (hact && !phact) begin
        if (hv[i]) chk($sformatf("u%0d.hs_period", i), 32'(cyc - t_hf[i]), 32'(cd[i] * htot(i)));
        t_hf[i] = cyc;
        hv[i]   = 1'b1;
      end
      if (!hact && phact && hv[i])
        chk($sformatf("u%0d.hs_width", i), 32'(cyc - t_hf[i]), 32'(cd[i] * hsw[i]));
      if (vact && !pvact) begin
        t_vf[i] = cyc;
        vv[i]   = 1'b1;
      end
      if (!vact && pvact && vv[i])
        chk($sformatf("u%0d.vs_width", i), 32'(cyc - t_vf[i]), 32'(cd[i] * htot(i) * vsw[i]));
      if (o.fs) begin
        if (fsv[i]) begin
          chk($sformatf("u%0d.frame_period", i), 32'(cyc - t_fs[i]), 32'(cd[i] * htot(i) * vtot(i)));
          chk($sformatf("u%0d.fetch_per_frame", i), 32'(fcnt[i]), 32'(ha[i] * va[i]));
        end
        fcnt[i] = 0;
        t_fs[i] = cyc;
        fsv[i]  = 1'b1;
      end
      if (o.fe) fcnt[i]++;
      prev[i] = o;
    end
  end

  // Cycles from the run rising edge to each instance's first frame_start.
  task automatic check_restart_latency();
    int lat [3] = '{-1, -1, -1};
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < 3; i++)
        if (lat[i] < 0 && obs[i].fs) lat[i] = k;
    end
    for (int i = 0; i < 3; i++)
      chk($sformatf("u%0d.fs_latency", i), 32'(lat[i]), 32'(cd[i]));
  endtask

  task automatic wait_col(input int target);
    bit found = 1'b0;
    for (int k = 0; k < 4000 && !found; k++) begin
      @(negedge clk);
      if (obs[2].col == 10'(target)) found = 1'b1;
    end
    chk($sformatf("wait_col_%0d", target), 32'(found), 32'd1);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    repeat (3) @(posedge clk);
    #2 run = 1'b1;
    check_restart_latency();
    repeat (5000) @(posedge clk);

    // Reset pulse in the middle of the default-mode HS pulse.
    wait_col(700);
    chk("u2.hs_before_reset", 32'(obs[2].hs), 32'd0);
    @(posedge clk);
    #2 reset = 1'b1;
    @(posedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    chk("u2.hs_after_reset", 32'(obs[2].hs), 32'd1);
    chk("u2.blank_after_reset", 32'(obs[2].blank), 32'd1);
    repeat (3000) @(posedge clk);

    // Stop the raster for 10 cycles mid-line, then restart.
    wait_col(500);
    @(posedge clk);
    #2 run = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("u2.blank_run_low", 32'(obs[2].blank), 32'd1);
    chk("u1.hs_run_low", 32'(obs[1].hs), 32'd0);
    chk("u1.vs_run_low", 32'(obs[1].vs), 32'd0);
    repeat (9) @(posedge clk);
    #2 run = 1'b1;
    check_restart_latency();
    repeat (3000) @(posedge clk);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
